// File: rtl/mc_mem_pkg.sv
// Shared memory-sizing helpers and read-path select encoding for the controller-side BRAM port.
// Index-width helpers are also used by the controller's counter sizing.
package mc_mem_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A one-word memory still needs a one-bit index port.
    function automatic int index_width(input int depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_ARRAY  = 2'd1,
        SEL_BYPASS = 2'd2
    } rd_sel_e;

endpackage

// File: rtl/mc_bram_array.sv
// Raw storage: synchronous write, registered synchronous read, no reset, so it maps onto block RAM.
// Latency 1 on reads; no backpressure, both ports accept every cycle.
module mc_bram_array #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 1024,
    parameter int IW        = 10
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_idx,
    input  logic [DATA_SIZE-1:0] wr_dat,
    input  logic                 rd_en,
    input  logic [IW-1:0]        rd_idx,
    output logic [DATA_SIZE-1:0] rd_dat
);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [DATA_SIZE-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem[rd_idx];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/mc_bram_port.sv
// Controller-facing BRAM port: range checks, write-first bypass, resettable read result, sticky OOB capture.
// Read latency 1; no backpressure, load and store complete every cycle they are enabled.
module mc_bram_port
    import mc_mem_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int DEPTH        = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_enable,
    input  logic [ADDRESS_SIZE-1:0] load_address,
    output logic [DATA_SIZE-1:0]    load_data,
    input  logic                    store_enable,
    input  logic [ADDRESS_SIZE-1:0] store_address,
    input  logic [DATA_SIZE-1:0]    store_data,
    output logic                    oob_error,
    output logic [ADDRESS_SIZE-1:0] oob_address,
    output logic                    oob_is_store
);

    localparam int IW = index_width(DEPTH);
    // One extra bit so the full address is compared and never truncated.
    localparam logic [ADDRESS_SIZE:0] DEPTH_A = (ADDRESS_SIZE + 1)'(DEPTH);

    logic ld_in_range;
    logic st_in_range;
    logic ld_ok;
    logic st_ok;
    logic ld_oob;
    logic st_oob;
    logic bypass;

    assign ld_in_range = ({1'b0, load_address} < DEPTH_A);
    assign st_in_range = ({1'b0, store_address} < DEPTH_A);
    assign ld_ok       = load_enable & ld_in_range;
    assign st_ok       = store_enable & st_in_range;
    assign ld_oob      = load_enable & ~ld_in_range;
    assign st_oob      = store_enable & ~st_in_range;
    assign bypass      = ld_ok & st_ok & (load_address == store_address);

    logic [DATA_SIZE-1:0] arr_rd_dat;

    mc_bram_array #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .IW        (IW)
    ) u_array (
        .clk    (clk),
        .wr_en  (st_ok),
        .wr_idx (store_address[IW-1:0]),
        .wr_dat (store_data),
        .rd_en  (ld_ok & ~bypass),
        .rd_idx (load_address[IW-1:0]),
        .rd_dat (arr_rd_dat)
    );

    rd_sel_e                 sel_q, sel_d;
    logic [DATA_SIZE-1:0]    byp_dat_q, byp_dat_d;
    logic                    oob_error_q, oob_error_d;
    logic [ADDRESS_SIZE-1:0] oob_address_q, oob_address_d;
    logic                    oob_is_store_q, oob_is_store_d;

    // Every source only changes on an enabled load, so an idle cycle holds load_data.
    always_comb begin
        sel_d     = sel_q;
        byp_dat_d = byp_dat_q;
        if (load_enable) begin
            if (!ld_in_range) begin
                sel_d = SEL_ZERO;
            end else if (bypass) begin
                sel_d     = SEL_BYPASS;
                byp_dat_d = store_data;
            end else begin
                sel_d = SEL_ARRAY;
            end
        end
    end

    always_comb begin
        oob_error_d    = oob_error_q;
        oob_address_d  = oob_address_q;
        oob_is_store_d = oob_is_store_q;
        if (!oob_error_q && (st_oob || ld_oob)) begin
            oob_error_d = 1'b1;
            if (st_oob) begin
                oob_address_d  = store_address;
                oob_is_store_d = 1'b1;
            end else begin
                oob_address_d  = load_address;
                oob_is_store_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q          <= SEL_ZERO;
            byp_dat_q      <= '0;
            oob_error_q    <= 1'b0;
            oob_address_q  <= '0;
            oob_is_store_q <= 1'b0;
        end else begin
            sel_q          <= sel_d;
            byp_dat_q      <= byp_dat_d;
            oob_error_q    <= oob_error_d;
            oob_address_q  <= oob_address_d;
            oob_is_store_q <= oob_is_store_d;
        end
    end

    always_comb begin
        load_data = '0;
        case (sel_q)
            SEL_ARRAY:  load_data = arr_rd_dat;
            SEL_BYPASS: load_data = byp_dat_q;
            default:    load_data = '0;
        endcase
    end

    assign oob_error    = oob_error_q;
    assign oob_address  = oob_address_q;
    assign oob_is_store = oob_is_store_q;

endmodule
